// File: rtl/core_wb_arbiter_if.sv
// Bus bundle between core_wb_arbiter, the pipeline writeback stage, the LU and the register file.
interface core_wb_arbiter_if #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
);
   logic            pipe_we_i;
   logic [RA_W-1:0] pipe_rd_addr_i;
   logic [XLEN-1:0] pipe_rd_din_i;
   logic            pipe_stall_o;
   logic            lu_valid_i;
   logic [RA_W-1:0] lu_rd_addr_i;
   logic [XLEN-1:0] lu_data_i;
   logic            lu_ready_o;
   logic            rf_we_o;
   logic [RA_W-1:0] rf_rd_addr_o;
   logic [XLEN-1:0] rf_rd_din_o;
   logic [1:0]      fifo_cnt_o;

   modport slave (
      input  pipe_we_i, pipe_rd_addr_i, pipe_rd_din_i,
      input  lu_valid_i, lu_rd_addr_i, lu_data_i,
      output pipe_stall_o, lu_ready_o,
      output rf_we_o, rf_rd_addr_o, rf_rd_din_o, fifo_cnt_o
   );

   modport master (
      output pipe_we_i, pipe_rd_addr_i, pipe_rd_din_i,
      output lu_valid_i, lu_rd_addr_i, lu_data_i,
      input  pipe_stall_o, lu_ready_o,
      input  rf_we_o, rf_rd_addr_o, rf_rd_din_o, fifo_cnt_o
   );
endinterface

// File: rtl/core_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. a 2-entry FIFO of long-latency results.
// Define WB_ARB_STARVE_EN to build the starvation counter that forces LU slots.
module core_wb_arbiter #(
   parameter int XLEN       = 32,
   parameter int RA_W       = 5,
   parameter int STARVE_MAX = 4
) (
   input logic              clk_i,
   input logic              rst_i,
   core_wb_arbiter_if.slave wb
);

   typedef enum logic [2:0] {
      GNT_NONE  = 3'd0,
      GNT_FORCE = 3'd1,
      GNT_PIPE  = 3'd2,
      GNT_FIFO  = 3'd3,
      GNT_BYP   = 3'd4
   } gnt_e;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [RA_W-1:0] addr0_r, addr1_r;
   logic [XLEN-1:0] data0_r, data1_r;
   logic [1:0]      count_r;

   logic [RA_W-1:0] n_addr0_s, n_addr1_s;
   logic [XLEN-1:0] n_data0_s, n_data1_s;
   logic [1:0]      n_count_s;

   logic            ready_s, push_s, pipe_eff_s, force_s;
   logic            pop_s, kill_s, keep0_s, keep1_s, store_s;
   gnt_e            gnt_s;

   logic            rf_we_s, stall_s;
   logic [RA_W-1:0] rf_addr_s;
   logic [XLEN-1:0] rf_din_s;

   assign ready_s    = !rst_i && (count_r != 2'd2);
   assign push_s     = wb.lu_valid_i && ready_s;
   assign pipe_eff_s = wb.pipe_we_i && (wb.pipe_rd_addr_i != {RA_W{1'b0}});

`ifdef WB_ARB_STARVE_EN
   logic [3:0] starve_r;

   assign force_s = (count_r != 2'd0) && (starve_r == STARVE_LIM);

   // Starvation counter: cleared whenever the FIFO is empty or wins, climbs while the pipeline keeps it waiting.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         starve_r <= 4'd0;
      end else if ((count_r == 2'd0) || pop_s) begin
         starve_r <= 4'd0;
      end else if ((gnt_s == GNT_PIPE) && (starve_r != STARVE_LIM)) begin
         starve_r <= starve_r + 4'd1;
      end else begin
         starve_r <= starve_r;
      end
   end
`else
   logic unused_starve_s;

   // Strict pipeline priority: the starvation limit has no effect in this build.
   assign force_s         = 1'b0;
   assign unused_starve_s = ^STARVE_LIM;
`endif

   // Grant selection in priority order.
   always_comb begin
      gnt_s = GNT_NONE;
      if (rst_i) begin
         gnt_s = GNT_NONE;
      end else if (force_s) begin
         gnt_s = GNT_FORCE;
      end else if (pipe_eff_s) begin
         gnt_s = GNT_PIPE;
      end else if (count_r != 2'd0) begin
         gnt_s = GNT_FIFO;
      end else if (push_s && (wb.lu_rd_addr_i != {RA_W{1'b0}})) begin
         gnt_s = GNT_BYP;
      end else begin
         gnt_s = GNT_NONE;
      end
   end

   // Write-port mux driven straight from the grant.
   always_comb begin
      rf_we_s   = 1'b0;
      rf_addr_s = {RA_W{1'b0}};
      rf_din_s  = {XLEN{1'b0}};
      stall_s   = 1'b0;
      case (gnt_s)
         GNT_FORCE: begin
            rf_we_s   = 1'b1;
            rf_addr_s = addr0_r;
            rf_din_s  = data0_r;
            stall_s   = wb.pipe_we_i;
         end
         GNT_PIPE: begin
            rf_we_s   = 1'b1;
            rf_addr_s = wb.pipe_rd_addr_i;
            rf_din_s  = wb.pipe_rd_din_i;
         end
         GNT_FIFO: begin
            rf_we_s   = 1'b1;
            rf_addr_s = addr0_r;
            rf_din_s  = data0_r;
         end
         GNT_BYP: begin
            rf_we_s   = 1'b1;
            rf_addr_s = wb.lu_rd_addr_i;
            rf_din_s  = wb.lu_data_i;
         end
         default: begin
            rf_we_s   = 1'b0;
            rf_addr_s = {RA_W{1'b0}};
            rf_din_s  = {XLEN{1'b0}};
            stall_s   = 1'b0;
         end
      endcase
   end

   // A granted pipeline write is younger than any buffered LU result to the same register.
   assign pop_s   = (gnt_s == GNT_FORCE) || (gnt_s == GNT_FIFO);
   assign kill_s  = (gnt_s == GNT_PIPE);
   assign keep0_s = (count_r != 2'd0) && !pop_s && !(kill_s && (addr0_r == wb.pipe_rd_addr_i));
   assign keep1_s = (count_r == 2'd2) && !(kill_s && (addr1_r == wb.pipe_rd_addr_i));
   assign store_s = push_s && (wb.lu_rd_addr_i != {RA_W{1'b0}}) && (gnt_s != GNT_BYP)
                    && !(kill_s && (wb.lu_rd_addr_i == wb.pipe_rd_addr_i));

   // Next FIFO contents: survivors compacted toward the head, then the new entry appended.
   always_comb begin
      n_addr0_s = addr0_r;
      n_data0_s = data0_r;
      n_addr1_s = addr1_r;
      n_data1_s = data1_r;
      n_count_s = {1'b0, keep0_s};
      if (keep1_s) begin
         if (keep0_s) begin
            n_addr1_s = addr1_r;
            n_data1_s = data1_r;
         end else begin
            n_addr0_s = addr1_r;
            n_data0_s = data1_r;
         end
         n_count_s = n_count_s + 2'd1;
      end else begin
         n_count_s = n_count_s;
      end
      if (store_s) begin
         if (n_count_s == 2'd0) begin
            n_addr0_s = wb.lu_rd_addr_i;
            n_data0_s = wb.lu_data_i;
         end else begin
            n_addr1_s = wb.lu_rd_addr_i;
            n_data1_s = wb.lu_data_i;
         end
         n_count_s = n_count_s + 2'd1;
      end else begin
         n_count_s = n_count_s;
      end
   end

   // FIFO storage and occupancy.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_r <= 2'd0;
         addr0_r <= {RA_W{1'b0}};
         addr1_r <= {RA_W{1'b0}};
         data0_r <= {XLEN{1'b0}};
         data1_r <= {XLEN{1'b0}};
      end else begin
         count_r <= n_count_s;
         addr0_r <= n_addr0_s;
         addr1_r <= n_addr1_s;
         data0_r <= n_data0_s;
         data1_r <= n_data1_s;
      end
   end

   assign wb.rf_we_o      = rf_we_s;
   assign wb.rf_rd_addr_o = rf_addr_s;
   assign wb.rf_rd_din_o  = rf_din_s;
   assign wb.pipe_stall_o = stall_s;
   assign wb.lu_ready_o   = ready_s;
   assign wb.fifo_cnt_o   = rst_i ? 2'd0 : count_r;

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Randomized bench for core_wb_arbiter against a queue-based model of the grant rules.
module tb_core_wb_arbiter;

   localparam int STARVE_MAX = 4;
`ifdef WB_ARB_STARVE_EN
   localparam bit STARVE_EN = 1'b1;
`else
   localparam bit STARVE_EN = 1'b0;
`endif

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   ent_t q[$];
   int   starve;

   core_wb_arbiter_if #(.XLEN(32), .RA_W(5)) bus ();

   core_wb_arbiter #(.XLEN(32), .RA_W(5), .STARVE_MAX(STARVE_MAX)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .wb    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs after the edge, check mid-cycle against the model, advance the model.
   task automatic step(input logic r, input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
      logic        e_we, e_st, e_rdy, push, peff;
      logic [4:0]  e_a;
      logic [31:0] e_d;
      int          src;
      @(posedge clk);
      #1;
      rst                = r;
      bus.pipe_we_i      = pwe;
      bus.pipe_rd_addr_i = pa;
      bus.pipe_rd_din_i  = pd;
      bus.lu_valid_i     = lv;
      bus.lu_rd_addr_i   = la;
      bus.lu_data_i      = ld;
      #3;
      e_we  = 1'b0;
      e_st  = 1'b0;
      e_a   = 5'd0;
      e_d   = 32'd0;
      src   = 0;
      e_rdy = !r && (q.size() < 2);
      check_val("fifo_cnt", 32'(bus.fifo_cnt_o), r ? 32'd0 : 32'(q.size()));
      if (r) begin
         q.delete();
         starve = 0;
      end else begin
         push = lv && e_rdy;
         peff = pwe && (pa != 5'd0);
         if (STARVE_EN && (q.size() > 0) && (starve == STARVE_MAX)) begin
            src  = 1;
            e_st = pwe;
         end else if (peff) begin
            src = 2;
         end else if (q.size() > 0) begin
            src = 1;
         end else if (push && (la != 5'd0)) begin
            src = 3;
         end
         if (src == 1) begin
            e_we = 1'b1; e_a = q[0].a; e_d = q[0].d;
         end else if (src == 2) begin
            e_we = 1'b1; e_a = pa; e_d = pd;
         end else if (src == 3) begin
            e_we = 1'b1; e_a = la; e_d = ld;
         end
         if ((q.size() == 0) || (src == 1)) starve = 0;
         else if ((src == 2) && (starve < STARVE_MAX)) starve++;
         if (src == 1) void'(q.pop_front());
         if (src == 2) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
               if (q[i].a == pa) q.delete(i);
            end
         end
         if (push && (la != 5'd0) && (src != 3) && !((src == 2) && (la == pa)))
            q.push_back(ent_t'{a: la, d: ld});
      end
      check_val("rf_we", 32'(bus.rf_we_o), 32'(e_we));
      check_val("pipe_stall", 32'(bus.pipe_stall_o), 32'(e_st));
      check_val("lu_ready", 32'(bus.lu_ready_o), 32'(e_rdy));
      if (e_we) begin
         check_val("rf_addr", 32'(bus.rf_rd_addr_o), 32'(e_a));
         check_val("rf_data", bus.rf_rd_din_o, e_d);
      end
   endtask

   initial begin
      int pct;
      errors             = 0;
      checks             = 0;
      starve             = 0;
      rst                = 1'b1;
      bus.pipe_we_i      = 1'b0;
      bus.pipe_rd_addr_i = 5'd0;
      bus.pipe_rd_din_i  = 32'd0;
      bus.lu_valid_i     = 1'b0;
      bus.lu_rd_addr_i   = 5'd0;
      bus.lu_data_i      = 32'd0;

      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

      // Bypass into an idle port.
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234);
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

      // Busy pipeline with two LU results queued, then the pipeline goes quiet.
      for (int i = 0; i < 14; i++)
         step(1'b0, 1'b1, 5'(10 + i), 32'(32'h100 + i), i < 2, (i == 0) ? 5'd3 : 5'd4, 32'(32'hD00 + i));
      for (int i = 0; i < 4; i++)
         step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

      // Younger pipeline write to a buffered register kills the stale LU value.
      step(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'h5555);
      step(1'b0, 1'b1, 5'd9, 32'hAAAA, 1'b0, 5'd0, 32'd0);
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

      // Pipeline write to x0 never blocks the FIFO; an LU push to x0 is swallowed.
      step(1'b0, 1'b1, 5'd2, 32'h22, 1'b1, 5'd5, 32'h5151);
      step(1'b0, 1'b1, 5'd0, 32'h33, 1'b0, 5'd0, 32'd0);
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h7777);
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

      // Reset with a full FIFO partway to a forced slot.
      step(1'b0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd12, 32'hC1);
      step(1'b0, 1'b1, 5'd6, 32'h67, 1'b1, 5'd13, 32'hC2);
      step(1'b0, 1'b1, 5'd6, 32'h68, 1'b0, 5'd0, 32'd0);
      step(1'b0, 1'b1, 5'd6, 32'h69, 1'b0, 5'd0, 32'd0);
      step(1'b1, 1'b1, 5'd6, 32'h6A, 1'b1, 5'd14, 32'hC3);
      step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

      // Random traffic with varying pipeline density and a small address space.
      for (int i = 0; i < 3000; i++) begin
         pct = (((i / 500) % 3) == 0) ? 90 : ((((i / 500) % 3) == 1) ? 50 : 10);
         step($urandom_range(0, 99) == 0,
              $urandom_range(0, 99) < pct, 5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
